// File: rtl/crc_stream_pkg.sv
// Shared types and helpers for the crc_stream block: FSM states, common
// polynomials and the unrolled multi-bit CRC update.
package crc_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam int unsigned CRC_MAX_W = 32;

    localparam logic [6:0]  CRC7_SD     = 7'h09;
    localparam logic [15:0] CRC16_CCITT = 16'h1021;
    localparam logic [31:0] CRC32       = 32'h04C11DB7;

    // Applies the serial shift-and-xor update to the nbits low bits of
    // 'bits', most significant first, on a register 'width' bits wide.
    function automatic logic [CRC_MAX_W-1:0] crc_step(
        input logic [CRC_MAX_W-1:0] crc_in,
        input logic [CRC_MAX_W-1:0] bits,
        input int unsigned          nbits,
        input int unsigned          width,
        input logic [CRC_MAX_W-1:0] poly
    );
        logic [CRC_MAX_W-1:0] r;
        logic [CRC_MAX_W-1:0] mask;
        logic                 fb;
        mask = (width >= CRC_MAX_W) ? '1 : ((32'd1 << width) - 32'd1);
        r    = crc_in & mask;
        for (int i = CRC_MAX_W - 1; i >= 0; i--) begin
            if (i < int'(nbits)) begin
                fb = r[5'(width - 1)] ^ bits[5'(i)];
                r  = ((r << 1) & mask) ^ (fb ? (poly & mask) : 32'd0);
            end
        end
        return r;
    endfunction

    // Counter width for a down-counter holding values 0..n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/crc_stream_emit.sv
// Append-phase streamer: holds the finished CRC and shifts it out MSB first,
// DATA_W bits per out handshake, flagging the final chunk.
module crc_stream_emit
    import crc_stream_pkg::*;
#(
    parameter int unsigned CRC_W  = 7,
    parameter int unsigned DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_abort,
    input  logic              i_load,
    input  logic [CRC_W-1:0]  i_snap,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);

    localparam int unsigned N_CHUNK = CRC_W / DATA_W;
    localparam int unsigned CNT_W   = cnt_width(N_CHUNK);

    logic              r_valid;
    logic              r_last;
    logic [CRC_W-1:0]  r_snap;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_fire;

    assign w_fire = r_valid & i_ready;

    // Snapshot is cleared after the final chunk so out_data idles at zero.
    always_ff @(posedge clk) begin
        if (rst || i_abort) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_snap  <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_last  <= (N_CHUNK == 1);
            r_snap  <= i_snap;
            r_cnt   <= CNT_W'(N_CHUNK - 1);
        end else if (w_fire) begin
            if (r_last) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_snap  <= '0;
                r_cnt   <= '0;
            end else begin
                r_snap  <= r_snap << DATA_W;
                r_cnt   <= r_cnt - CNT_W'(1);
                r_last  <= (r_cnt == CNT_W'(1));
            end
        end
    end

    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_data  = r_snap[CRC_W-1 -: DATA_W];

endmodule

// File: rtl/crc_stream.sv
// Parametrised streaming CRC generator with valid/ready framing and optional
// append phase. Define CRC_STREAM_CHECK_EN to add the expected-CRC comparator.
module crc_stream
    import crc_stream_pkg::*;
#(
    parameter int unsigned      CRC_W   = 7,
    parameter logic [CRC_W-1:0] POLY    = 7'h09,
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOR_OUT = '0,
    parameter int unsigned      DATA_W  = 1,
    parameter int unsigned      APPEND  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [CRC_W-1:0]  crc,
    output logic              busy,
    output logic              done
`ifdef CRC_STREAM_CHECK_EN
    ,
    input  logic [CRC_W-1:0]  exp_crc,
    output logic              crc_ok,
    output logic              crc_ok_valid
`endif
);

    generate
        if (CRC_W == 0 || CRC_W > CRC_MAX_W) begin : g_bad_crc_w
            $error("crc_stream: CRC_W must be in 1..32");
        end
        if (DATA_W == 0 || DATA_W > CRC_W) begin : g_bad_data_w
            $error("crc_stream: DATA_W must be in 1..CRC_W");
        end else if ((CRC_W % DATA_W) != 0) begin : g_bad_ratio
            $error("crc_stream: CRC_W must be a multiple of DATA_W");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic [CRC_W-1:0] r_crc_reg;
    logic [CRC_W-1:0] w_crc_step;
    logic [CRC_W-1:0] w_crc_next;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;
    logic             w_accept;
    logic             w_accept_last;
    logic             w_load_emit;
    logic             w_complete;
    logic             w_last_hs;

    always_comb begin
        w_crc_step = CRC_W'(crc_step(32'(r_crc_reg), 32'(in_data), DATA_W, CRC_W, 32'(POLY)));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; start always wins and restarts the frame
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) w_state_next = RUN;
            end
            RUN: begin
                if (start)              w_state_next = RUN;
                else if (w_accept_last) w_state_next = (APPEND != 0) ? EMIT : IDLE;
            end
            EMIT: begin
                if (start)          w_state_next = RUN;
                else if (w_last_hs) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath controls derived from the current state and handshakes
    always_comb begin
        w_accept      = 1'b0;
        w_accept_last = 1'b0;
        w_load_emit   = 1'b0;
        w_complete    = 1'b0;
        w_crc_next    = r_crc_reg;
        w_last_hs     = out_valid & out_ready & out_last;
        if (start) begin
            w_crc_next = INIT;
        end else begin
            unique case (r_state)
                RUN: begin
                    w_accept      = in_valid & r_in_ready;
                    w_accept_last = w_accept & in_last;
                    w_load_emit   = w_accept_last && (APPEND != 0);
                    w_complete    = w_accept_last && (APPEND == 0);
                    if (w_accept) w_crc_next = w_crc_step;
                end
                EMIT: begin
                    w_complete = w_last_hs;
                end
                default: ;
            endcase
        end
    end

    // Registered outputs and the working CRC register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc_reg  <= INIT;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_crc_reg  <= w_crc_next;
            r_in_ready <= (w_state_next == RUN);
            r_busy     <= (w_state_next != IDLE);
            r_done     <= w_complete;
        end
    end

    crc_stream_emit #(
        .CRC_W  (CRC_W),
        .DATA_W (DATA_W)
    ) u_emit (
        .clk     (clk),
        .rst     (rst),
        .i_abort (start),
        .i_load  (w_load_emit),
        .i_snap  (w_crc_step ^ XOR_OUT),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_last  (out_last)
    );

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign crc      = r_crc_reg ^ XOR_OUT;

`ifdef CRC_STREAM_CHECK_EN
    logic [CRC_W-1:0] r_exp_crc;
    logic [CRC_W-1:0] w_exp_sel;
    logic             r_crc_ok;
    logic             r_crc_ok_valid;

    // Without an append phase the frame completes on the same edge exp_crc is sampled
    assign w_exp_sel = w_accept_last ? exp_crc : r_exp_crc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp_crc      <= '0;
            r_crc_ok       <= 1'b0;
            r_crc_ok_valid <= 1'b0;
        end else begin
            if (w_accept_last) r_exp_crc <= exp_crc;
            r_crc_ok_valid <= w_complete;
            r_crc_ok       <= w_complete && ((w_crc_next ^ XOR_OUT) == w_exp_sel);
        end
    end

    assign crc_ok       = r_crc_ok;
    assign crc_ok_valid = r_crc_ok_valid;
`endif

endmodule

// File: tb/tb_crc_stream.sv
// Self-checking bench for crc_stream: a CRC7 bit-serial instance and a CRC16
// byte-wide instance, checked against a polynomial long-division model.
module tb_crc_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst;
    int          cur;
    logic        start_c, iv_c, last_c, ordy_c;
    logic [7:0]  d_c;
    logic [15:0] exp_c;

    logic        start7, iv7, last7, ordy7, ir7, ov7, ol7, busy7, done7;
    logic [0:0]  d7, od7;
    logic [6:0]  crc7, exp7;
    logic        start16, iv16, last16, ordy16, ir16, ov16, ol16, busy16, done16;
    logic [7:0]  d16, od16;
    logic [15:0] crc16, exp16;

    assign start7  = start_c && (cur == 0);
    assign iv7     = iv_c && (cur == 0);
    assign last7   = last_c;
    assign ordy7   = ordy_c && (cur == 0);
    assign d7      = d_c[0:0];
    assign exp7    = exp_c[6:0];
    assign start16 = start_c && (cur == 1);
    assign iv16    = iv_c && (cur == 1);
    assign last16  = last_c;
    assign ordy16  = ordy_c && (cur == 1);
    assign d16     = d_c;
    assign exp16   = exp_c;

`ifdef CRC_STREAM_CHECK_EN
    logic ok7, okv7, ok16, okv16;
`endif

    crc_stream #(.CRC_W(7), .POLY(7'h09), .INIT(7'h00), .XOR_OUT(7'h00), .DATA_W(1), .APPEND(1)) u_crc7 (
        .clk(clk), .rst(rst), .start(start7), .in_valid(iv7), .in_ready(ir7), .in_data(d7),
        .in_last(last7), .out_valid(ov7), .out_ready(ordy7), .out_data(od7), .out_last(ol7),
        .crc(crc7), .busy(busy7), .done(done7)
`ifdef CRC_STREAM_CHECK_EN
        , .exp_crc(exp7), .crc_ok(ok7), .crc_ok_valid(okv7)
`endif
    );

    crc_stream #(.CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .XOR_OUT(16'h0000), .DATA_W(8), .APPEND(1)) u_crc16 (
        .clk(clk), .rst(rst), .start(start16), .in_valid(iv16), .in_ready(ir16), .in_data(d16),
        .in_last(last16), .out_valid(ov16), .out_ready(ordy16), .out_data(od16), .out_last(ol16),
        .crc(crc16), .busy(busy16), .done(done16)
`ifdef CRC_STREAM_CHECK_EN
        , .exp_crc(exp16), .crc_ok(ok16), .crc_ok_valid(okv16)
`endif
    );

    // Views of whichever instance is currently under test
    logic [31:0] v_crc, v_od;
    logic        v_ir, v_ov, v_ol, v_busy, v_done, v_ok, v_okv;
    always_comb begin
        v_crc  = (cur == 1) ? 32'(crc16)  : 32'(crc7);
        v_od   = (cur == 1) ? 32'(od16)   : 32'(od7);
        v_ir   = (cur == 1) ? ir16   : ir7;
        v_ov   = (cur == 1) ? ov16   : ov7;
        v_ol   = (cur == 1) ? ol16   : ol7;
        v_busy = (cur == 1) ? busy16 : busy7;
        v_done = (cur == 1) ? done16 : done7;
`ifdef CRC_STREAM_CHECK_EN
        v_ok   = (cur == 1) ? ok16   : ok7;
        v_okv  = (cur == 1) ? okv16  : okv7;
`else
        v_ok   = 1'b0;
        v_okv  = 1'b0;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Remainder of M(x)*x^w divided by x^w + poly, by explicit long division
    function automatic logic [31:0] ref_crc(input bit msg[$], input int w, input logic [31:0] poly);
        bit          m[$];
        logic [31:0] r;
        m = msg;
        for (int i = 0; i < w; i++) m.push_back(1'b0);
        for (int i = 0; i < msg.size(); i++) begin
            if (m[i]) begin
                for (int j = 0; j <= w; j++) m[i+j] = m[i+j] ^ ((j == 0) ? 1'b1 : poly[w-j]);
            end
        end
        r = '0;
        for (int k = 0; k < w; k++) r[w-1-k] = m[msg.size()+k];
        return r;
    endfunction

    // Full frame: start, beats with random gaps, emit with random stalls, done
    task automatic do_frame(input int sel, input logic [7:0] msg[$], input int stall_pct,
                            input logic [15:0] exp_in, output logic [31:0] got);
        int          w, dw, nbeats, nchunk, idx;
        logic [31:0] poly, expv, chunk, mask, prev_od;
        logic [7:0]  beat;
        bit          bits[$];
        bit          allbits[$];
        bit          fin, prev_stall;
        cur    = sel;
        w      = (sel == 1) ? 16 : 7;
        dw     = (sel == 1) ? 8 : 1;
        poly   = (sel == 1) ? 32'h1021 : 32'h09;
        exp_c  = exp_in;
        foreach (msg[i]) for (int b = 7; b >= 0; b--) allbits.push_back(msg[i][b]);
        expv   = ref_crc(allbits, w, poly);
        nbeats = (sel == 1) ? msg.size() : msg.size() * 8;
        start_c = 1'b1; tick(); start_c = 1'b0;
        chk("start_busy", 32'(v_busy), 32'd1);
        chk("start_in_ready", 32'(v_ir), 32'd1);
        chk("start_crc_init", v_crc, 32'd0);
        for (int k = 0; k < nbeats; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                iv_c = 1'b0; tick();
                chk("gap_crc_hold", v_crc, ref_crc(bits, w, poly));
            end
            beat   = (sel == 1) ? msg[k] : {7'b0, msg[k/8][7-(k%8)]};
            iv_c   = 1'b1;
            d_c    = beat;
            last_c = (k == nbeats - 1);
            for (int j = 0; j < dw; j++) bits.push_back(beat[dw-1-j]);
            tick();
            chk("beat_crc", v_crc, ref_crc(bits, w, poly));
        end
        iv_c = 1'b0; last_c = 1'b0;
        chk("emit_in_ready", 32'(v_ir), 32'd0);
        nchunk = w / dw; mask = (32'd1 << dw) - 32'd1;
        idx = 0; fin = 1'b0; prev_stall = 1'b0; prev_od = '0;
        for (int c = 0; c < 400 && !fin; c++) begin
            chunk = (expv >> (w - dw * (idx + 1))) & mask;
            chk("out_valid", 32'(v_ov), 32'd1);
            chk("out_data", v_od, chunk);
            chk("out_last", 32'(v_ol), 32'(idx == nchunk - 1));
            if (prev_stall) chk("stall_data_stable", v_od, prev_od);
            ordy_c     = ($urandom_range(0, 99) >= stall_pct);
            prev_stall = !ordy_c;
            prev_od    = v_od;
            if (ordy_c) begin
                if (idx == nchunk - 1) fin = 1'b1;
                idx++;
            end
            tick();
        end
        ordy_c = 1'b0;
        chk("emit_chunks", 32'(idx), 32'(nchunk));
        chk("done_pulse", 32'(v_done), 32'd1);
        chk("idle_out_valid", 32'(v_ov), 32'd0);
        chk("idle_busy", 32'(v_busy), 32'd0);
        chk("final_crc", v_crc, expv);
`ifdef CRC_STREAM_CHECK_EN
        chk("crc_ok_valid", 32'(v_okv), 32'd1);
        chk("crc_ok", 32'(v_ok), 32'((exp_in & 16'(mask | ((32'd1 << w) - 32'd1))) == 16'(expv)));
`endif
        got = v_crc;
        tick();
        chk("done_one_cycle", 32'(v_done), 32'd0);
        chk("crc_holds", v_crc, expv);
        chk("ok_valid_low", 32'(v_okv), 32'd0);
    endtask

    // Feeds the first nbits bits of msg to the CRC7 instance, never marking last
    task automatic feed7(input logic [7:0] msg[$], input int nbits);
        bit bits[$];
        cur = 0;
        for (int k = 0; k < nbits; k++) begin
            iv_c = 1'b1; last_c = 1'b0;
            d_c  = {7'b0, msg[k/8][7-(k%8)]};
            bits.push_back(d_c[0]);
            tick();
            chk("feed_crc", v_crc, ref_crc(bits, 7, 32'h09));
        end
        iv_c = 1'b0;
    endtask

    logic [7:0]  cmd0[$], cmd8[$], digits[$], rmsg[$];
    logic [31:0] got;

    initial begin
        cmd0   = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
        cmd8   = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA};
        digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        rst = 1'b1; cur = 0; start_c = 1'b0; iv_c = 1'b0; last_c = 1'b0;
        ordy_c = 1'b0; d_c = '0; exp_c = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(v_busy), 32'd0);
        chk("rst_in_ready", 32'(v_ir), 32'd0);
        chk("rst_out_valid", 32'(v_ov), 32'd0);
        chk("rst_out_last", 32'(v_ol), 32'd0);
        chk("rst_out_data", v_od, 32'd0);
        chk("rst_done", 32'(v_done), 32'd0);
        chk("rst_crc7", v_crc, 32'd0);
        chk("rst_crc16", 32'(crc16), 32'd0);
        rst = 1'b0; tick();

        do_frame(0, cmd0, 0, 16'h004A, got);
        chk("cmd0_crc7", got, 32'h4A);
        do_frame(0, cmd8, 40, 16'h0043, got);
        chk("cmd8_crc7", got, 32'h43);
        do_frame(1, digits, 0, 16'h31C3, got);
        chk("digits_crc16", got, 32'h31C3);
        do_frame(1, digits, 30, 16'h31C2, got);
        chk("digits_crc16_stall", got, 32'h31C3);

        // Abort during EMIT after the first chunk
        cur = 0; start_c = 1'b1; tick(); start_c = 1'b0;
        feed7(cmd0, 39);
        iv_c = 1'b1; last_c = 1'b1; d_c = {7'b0, cmd0[4][0]}; tick();
        iv_c = 1'b0; last_c = 1'b0;
        chk("abort_pre_ov", 32'(v_ov), 32'd1);
        ordy_c = 1'b1; tick(); ordy_c = 1'b0;
        start_c = 1'b1; tick(); start_c = 1'b0;
        chk("abort_out_valid", 32'(v_ov), 32'd0);
        chk("abort_crc_init", v_crc, 32'd0);
        chk("abort_busy", 32'(v_busy), 32'd1);
        chk("abort_done", 32'(v_done), 32'd0);
        tick();
        chk("abort_no_done", 32'(v_done), 32'd0);
        do_frame(0, cmd8, 30, 16'h0000, got);
        chk("post_abort_crc7", got, 32'h43);

        // start coinciding with an in_last beat discards the beat
        start_c = 1'b1; tick(); start_c = 1'b0;
        feed7(cmd0, 39);
        iv_c = 1'b1; last_c = 1'b1; start_c = 1'b1; d_c = 8'h01; tick();
        iv_c = 1'b0; last_c = 1'b0; start_c = 1'b0;
        chk("sl_out_valid", 32'(v_ov), 32'd0);
        chk("sl_crc_init", v_crc, 32'd0);
        chk("sl_in_ready", 32'(v_ir), 32'd1);
        tick();
        chk("sl_no_done", 32'(v_done), 32'd0);

        // Reset in RUN after 20 bits, then in_valid ignored until start
        feed7(cmd8, 20);
        rst = 1'b1; tick();
        chk("mrst_busy", 32'(v_busy), 32'd0);
        chk("mrst_in_ready", 32'(v_ir), 32'd0);
        chk("mrst_crc", v_crc, 32'd0);
        chk("mrst_done", 32'(v_done), 32'd0);
        rst = 1'b0; iv_c = 1'b1; d_c = 8'h01;
        repeat (3) tick();
        chk("ignore_crc", v_crc, 32'd0);
        chk("ignore_busy", 32'(v_busy), 32'd0);
        chk("ignore_done", 32'(v_done), 32'd0);
        start_c = 1'b1; tick(); start_c = 1'b0; iv_c = 1'b0;
        chk("start_iv_not_taken", v_crc, 32'd0);
        chk("start_iv_in_ready", 32'(v_ir), 32'd1);

        // Random frames on both instances
        for (int r = 0; r < 4; r++) begin
            rmsg.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) rmsg.push_back(8'($urandom));
            do_frame(0, rmsg, 25, 16'($urandom), got);
            do_frame(1, rmsg, 25, 16'($urandom), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
